// File: rtl/sram_sample_fetch.sv
// SRAM DMA read engine: fetches a block of 32-bit words into a small FIFO
// and unpacks them into 16-bit PCM samples on request from the synthesizer.
module sram_sample_fetch #(
  parameter int          READ_LAT   = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] SRAM_BEGIN = 32'h1000_0000,
  parameter logic [31:0] SRAM_END   = 32'h101F_FFFF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [31:0] iBaseAddr,
  input  logic [15:0] iLength,
  input  logic        iLoop,
  input  logic        iStop,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic        oReadEnableS,
  output logic [31:0] oAddressS,
  input  logic [31:0] iReadDataS,
  input  logic        iSampleReq,
  output logic [15:0] oSample,
  output logic        oSampleValid,
  output logic        oUnderflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, HOLD, DONE} state_t;

  state_t            state, stateNext;
  logic [31:0]       baseAddr;
  logic [15:0]       lenWords;
  logic              loopEn;
  logic [15:0]       wordIdx, wordIdxNext;
  logic [LAT_W-1:0]  latCnt, latCntNext;

  logic [31:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  fifoCnt, cntAfter;
  logic              halfSel;

  logic [31:0]       baseIn, baseSel, addrNext;
  logic [33:0]       lastIn;
  logic              rangeBad, startOk, startZero, startGo, startErr;
  logic              flush, pushEn, popEn, reqServe, reqUnder;
  logic              rdEnNext, doneNext;

  function automatic logic [15:0] pickHalf(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

  // Start qualification and range check on the not-yet-latched request
  always_comb begin
    baseIn    = {iBaseAddr[31:2], 2'b00};
    lastIn    = {2'b00, baseIn} + {16'b0, iLength - 16'd1, 2'b00};
    rangeBad  = (baseIn < SRAM_BEGIN) || (lastIn > {2'b00, SRAM_END});
    startOk   = iStart && !iStop && (state == IDLE);
    startZero = startOk && (iLength == 16'd0);
    startGo   = startOk && (iLength != 16'd0) && !rangeBad;
    startErr  = startOk && (iLength != 16'd0) && rangeBad;
    flush     = iStop || startGo;
    pushEn    = (state == CAPTURE) && !iStop;
    reqServe  = iSampleReq && !flush && (fifoCnt != '0);
    reqUnder  = iSampleReq && !flush && (fifoCnt == '0);
    popEn     = reqServe && halfSel;
    unique case ({pushEn, popEn})
      2'b10:   cntAfter = fifoCnt + 1'b1;
      2'b01:   cntAfter = fifoCnt - 1'b1;
      default: cntAfter = fifoCnt;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    wordIdxNext = wordIdx;
    latCntNext  = latCnt;
    if (iStop) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (startZero) begin
            stateNext = DONE;
          end else if (startGo) begin
            stateNext   = WAIT;
            wordIdxNext = '0;
            latCntNext  = '0;
          end
        end
        WAIT: begin
          if (latCnt == LAT_LAST) stateNext = CAPTURE;
          else                    latCntNext = latCnt + 1'b1;
        end
        CAPTURE: begin
          latCntNext = '0;
          if (wordIdx == lenWords - 16'd1) begin
            if (loopEn) begin
              wordIdxNext = '0;
              stateNext   = (cntAfter < CNT_FULL) ? WAIT : HOLD;
            end else begin
              stateNext = DONE;
            end
          end else begin
            wordIdxNext = wordIdx + 16'd1;
            stateNext   = (cntAfter < CNT_FULL) ? WAIT : HOLD;
          end
        end
        HOLD: begin
          latCntNext = '0;
          if (cntAfter < CNT_FULL) stateNext = WAIT;
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Registered bus outputs are computed from the next state so they stay flat across a WAIT window
  always_comb begin
    baseSel  = startGo ? baseIn : baseAddr;
    rdEnNext = (stateNext == WAIT);
    addrNext = rdEnNext ? baseSel + {14'b0, wordIdxNext, 2'b00} : oAddressS;
    doneNext = (state == DONE) && !iStop;
  end

  assign oBusy = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wordIdx      <= '0;
      latCnt       <= '0;
      oReadEnableS <= 1'b0;
      oAddressS    <= '0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
    end else begin
      wordIdx      <= wordIdxNext;
      latCnt       <= latCntNext;
      oReadEnableS <= rdEnNext;
      oAddressS    <= addrNext;
      oDone        <= doneNext;
      if (startErr) oError <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (startGo) begin
      baseAddr <= baseIn;
      lenWords <= iLength;
      loopEn   <= iLoop;
    end
    if (pushEn) fifoMem[wrPtr] <= iReadDataS;
  end

  // Word FIFO bookkeeping and sample unpack stage
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      fifoCnt      <= '0;
      halfSel      <= 1'b0;
      oSample      <= '0;
      oSampleValid <= 1'b0;
      oUnderflow   <= 1'b0;
    end else begin
      oSampleValid <= 1'b0;
      if (flush) begin
        wrPtr   <= '0;
        rdPtr   <= '0;
        fifoCnt <= '0;
        halfSel <= 1'b0;
      end else begin
        if (pushEn) wrPtr <= wrPtr + 1'b1;
        if (popEn)  rdPtr <= rdPtr + 1'b1;
        fifoCnt <= cntAfter;
        if (reqServe) begin
          oSample      <= pickHalf(fifoMem[rdPtr], halfSel);
          oSampleValid <= 1'b1;
          halfSel      <= ~halfSel;
        end
      end
      if (reqUnder) begin
        oSample    <= '0;
        oUnderflow <= 1'b1;
      end
      if (startGo) oUnderflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_sample_fetch.sv
// Directed bench for sram_sample_fetch with a fixed-latency SRAM read model.
module tb_sram_sample_fetch;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic [31:0] iBaseAddr;
  logic [15:0] iLength;
  logic        iLoop;
  logic        iStop;
  logic        oBusy, oDone, oError, oReadEnableS;
  logic [31:0] oAddressS;
  logic [31:0] iReadDataS;
  logic        iSampleReq;
  logic [15:0] oSample;
  logic        oSampleValid, oUnderflow;

  int errCnt = 0;
  int chkCnt = 0;

  logic [31:0] memW [0:7];
  logic [31:0] a1, a2;
  logic [31:0] addrLog [0:7];
  logic [15:0] expS [0:5];
  int nRise, doneCnt, enHigh;
  logic prevEn, found;

  sram_sample_fetch dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iBaseAddr(iBaseAddr),
    .iLength(iLength), .iLoop(iLoop), .iStop(iStop), .oBusy(oBusy),
    .oDone(oDone), .oError(oError), .oReadEnableS(oReadEnableS),
    .oAddressS(oAddressS), .iReadDataS(iReadDataS), .iSampleReq(iSampleReq),
    .oSample(oSample), .oSampleValid(oSampleValid), .oUnderflow(oUnderflow)
  );

  always #5 iCLK = ~iCLK;

  // Two-cycle read latency: data reflects the address presented two cycles earlier
  always @(posedge iCLK) begin
    a1 <= oAddressS;
    a2 <= a1;
  end
  assign iReadDataS = memW[a2[4:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic startJob(input logic [31:0] base, input logic [15:0] len, input logic lp);
    iBaseAddr = base;
    iLength   = len;
    iLoop     = lp;
    iStart    = 1'b1;
    step();
    iStart    = 1'b0;
  endtask

  task automatic req();
    iSampleReq = 1'b1;
    step();
    iSampleReq = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    iRST = 1'b1; iStart = 0; iBaseAddr = 0; iLength = 0; iLoop = 0;
    iStop = 0; iSampleReq = 0;
    for (int i = 0; i < 8; i++) memW[i] = 32'h0;
    step();
    step();
    chk("rst_busy", oBusy, 0);
    chk("rst_rden", oReadEnableS, 0);
    chk("rst_addr", oAddressS, 0);
    chk("rst_sample", oSample, 0);
    chk("rst_flags", {oDone, oError, oSampleValid, oUnderflow}, 0);
    iRST = 1'b0;
    step();

    // Three-word block, then six sample requests
    memW[0] = 32'hAAAA5555; memW[1] = 32'h22221111; memW[2] = 32'h44443333;
    startJob(32'h1000_0000, 16'd3, 1'b0);
    chk("t1_rden_c1", oReadEnableS, 1);
    chk("t1_addr0", oAddressS, 32'h1000_0000);
    nRise = 1; prevEn = 1'b1; doneCnt = 0;
    repeat (20) begin
      step();
      if (oReadEnableS && !prevEn) begin
        if (nRise < 8) addrLog[nRise] = oAddressS;
        nRise++;
      end
      prevEn = oReadEnableS;
      if (oDone) doneCnt++;
    end
    chk("t1_reads", nRise, 3);
    chk("t1_addr1", addrLog[1], 32'h1000_0004);
    chk("t1_addr2", addrLog[2], 32'h1000_0008);
    chk("t1_done_cnt", doneCnt, 1);
    chk("t1_idle", oBusy, 0);
    expS[0] = 16'h5555; expS[1] = 16'hAAAA; expS[2] = 16'h1111;
    expS[3] = 16'h2222; expS[4] = 16'h3333; expS[5] = 16'h4444;
    for (int i = 0; i < 6; i++) begin
      req();
      chk($sformatf("t1_valid%0d", i), oSampleValid, 1);
      chk($sformatf("t1_sample%0d", i), oSample, expS[i]);
    end
    chk("t1_no_underflow", oUnderflow, 0);

    // One word drained, then an underflowing request
    memW[4] = 32'h5678_1234;
    startJob(32'h1000_0010, 16'd1, 1'b0);
    repeat (8) step();
    req();
    chk("t4_lo", oSample, 16'h1234);
    req();
    chk("t4_hi", oSample, 16'h5678);
    req();
    chk("t4_uf_valid", oSampleValid, 0);
    chk("t4_uf_sample", oSample, 0);
    chk("t4_uf_flag", oUnderflow, 1);

    // Looping two-word block fills the FIFO and stalls
    memW[0] = 32'hB000_A000; memW[1] = 32'hD000_C000;
    startJob(32'h1000_0000, 16'd2, 1'b1);
    chk("loop_uf_cleared", oUnderflow, 0);
    nRise = 1; addrLog[0] = oAddressS; prevEn = 1'b1; enHigh = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (oReadEnableS && !prevEn) begin
        if (nRise < 8) addrLog[nRise] = oAddressS;
        nRise++;
      end
      prevEn = oReadEnableS;
      if (c >= 20 && oReadEnableS) enHigh++;
    end
    chk("loop_reads", nRise, 4);
    chk("loop_a0", addrLog[0], 32'h1000_0000);
    chk("loop_a1", addrLog[1], 32'h1000_0004);
    chk("loop_a2", addrLog[2], 32'h1000_0000);
    chk("loop_a3", addrLog[3], 32'h1000_0004);
    chk("loop_stalled", enHigh, 0);
    chk("loop_busy", oBusy, 1);
    req();
    chk("loop_s0", oSample, 16'hA000);
    req();
    chk("loop_s1", oSample, 16'hB000);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      if (oReadEnableS) found = 1'b1;
      else step();
    end
    chk("loop_resume", found, 1);
    chk("loop_resume_addr", oAddressS, 32'h1000_0000);

    // Stop during WAIT with three words buffered
    iStop = 1'b1;
    step();
    iStop = 1'b0;
    chk("stop_busy", oBusy, 0);
    chk("stop_rden", oReadEnableS, 0);
    doneCnt = 0;
    repeat (6) begin
      step();
      if (oDone) doneCnt++;
    end
    chk("stop_no_done", doneCnt, 0);
    req();
    chk("stop_flushed_valid", oSampleValid, 0);
    chk("stop_flushed_uf", oUnderflow, 1);

    // Zero-length start
    startJob(32'h1000_0000, 16'd0, 1'b0);
    chk("len0_c1_rden", oReadEnableS, 0);
    chk("len0_c1_done", oDone, 0);
    step();
    chk("len0_c2_done", oDone, 1);
    step();
    chk("len0_c3_done", oDone, 0);
    chk("len0_c3_busy", oBusy, 0);

    // Range error: last word past the end of SRAM
    startJob(32'h101F_FFFC, 16'd2, 1'b0);
    chk("err_flag", oError, 1);
    chk("err_busy", oBusy, 0);
    chk("err_rden", oReadEnableS, 0);
    step();
    chk("err_sticky", oError, 1);

    // Reset in the middle of a WAIT window
    startJob(32'h1000_0000, 16'd3, 1'b0);
    step();
    chk("rstw_rden", oReadEnableS, 1);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("rstw_rden_off", oReadEnableS, 0);
    chk("rstw_busy", oBusy, 0);
    chk("rstw_addr", oAddressS, 0);
    chk("rstw_flags", {oDone, oError, oSampleValid, oUnderflow}, 0);
    step();
    chk("rstw_stays_idle", {oBusy, oReadEnableS}, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
